// File: rtl/instr_sequencer_if.sv
// Host-load, program-memory and register-file bundle of the instruction sequencer.
// The master modport is the sequencer side; slave is the host/memory/regfile side.
interface instr_sequencer_if #(
    parameter int ADDR  = 4,
    parameter int WIDTH = 8
) ();
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             mem_cs;
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic [1:0]       alu_op;
    logic             rf_we;
    logic [1:0]       rf_sel;
    logic [WIDTH-1:0] rf_wdata;

    modport master (
        input  load_valid, load_data, mem_rdata,
        output load_ready, mem_cs, mem_we, mem_addr, mem_wdata,
        output alu_op, rf_we, rf_sel, rf_wdata
    );

    modport slave (
        output load_valid, load_data, mem_rdata,
        input  load_ready, mem_cs, mem_we, mem_addr, mem_wdata,
        input  alu_op, rf_we, rf_sel, rf_wdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Loads a program into external memory, then fetches, waits and executes one word
// at a time, issuing register-file writebacks until a halt opcode, end of program or halt request.
module instr_sequencer #(
    parameter int ADDR   = 4,
    parameter int WIDTH  = 8,
    parameter int LENGTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    output logic [ADDR-1:0] pc,
    output logic            busy,
    output logic            done,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, EXEC, HALT} state_t;

    localparam logic [ADDR-1:0]  LAST    = ADDR'(LENGTH - 1);
    localparam logic [WIDTH-1:0] HALT_OP = '1;

    state_t          state, state_nx;
    logic [ADDR-1:0] lptr, lptr_nx, pc_nx;
    logic            pending, pending_nx;
    logic            halt_op;
    logic            is_halt;

    function automatic logic [WIDTH-1:0] zext_nibble(input logic [WIDTH-1:0] w);
        return {{(WIDTH-4){1'b0}}, w[3:0]};
    endfunction

    assign is_halt = (bus.mem_rdata == HALT_OP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            lptr        <= '0;
            pending     <= 1'b0;
            halt_op     <= 1'b0;
            bus.rf_we   <= 1'b0;
            bus.alu_op  <= '0;
            bus.rf_sel  <= '0;
            bus.rf_wdata <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            lptr      <= lptr_nx;
            pending   <= pending_nx;
            bus.rf_we <= 1'b0;
            // Read data is valid in WAIT; decode it so EXEC presents the writeback.
            if (state == WAIT) begin
                halt_op   <= is_halt;
                bus.rf_we <= !is_halt;
                if (!is_halt) begin
                    bus.rf_sel   <= bus.mem_rdata[7:6];
                    bus.alu_op   <= bus.mem_rdata[5:4];
                    bus.rf_wdata <= zext_nibble(bus.mem_rdata);
                end
            end
        end
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        lptr_nx        = lptr;
        pending_nx     = pending;
        bus.load_ready = 1'b0;
        bus.mem_cs     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state)
            IDLE, LOAD: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    bus.mem_cs    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = lptr;
                    bus.mem_wdata = bus.load_data;
                    lptr_nx       = (lptr == LAST) ? '0 : lptr + 1'b1;
                    state_nx      = (lptr == LAST) ? IDLE : LOAD;
                end else if (state == IDLE && start) begin
                    pc_nx    = '0;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                busy         = 1'b1;
                bus.mem_cs   = 1'b1;
                bus.mem_addr = pc;
                pending_nx   = pending | halt_req;
                state_nx     = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                pending_nx = pending | halt_req;
                state_nx   = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                pending_nx = pending | halt_req;
                if (halt_op) begin
                    state_nx = HALT;
                end else begin
                    // pc saturates at the last word rather than wrapping.
                    pc_nx    = (pc == LAST) ? pc : pc + 1'b1;
                    state_nx = (pc == LAST || pending || halt_req) ? HALT : FETCH;
                end
            end
            HALT: begin
                done = 1'b1;
                if (start) begin
                    pending_nx = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: program memory model, write/writeback
// monitors and a program-level reference model of the expected execution trace.
module tb_instr_sequencer;
    localparam int ADDR = 4, WIDTH = 8, LENGTH = 16;

    logic            clk = 1'b0;
    logic            reset, start, halt_req;
    logic [ADDR-1:0] pc;
    logic            busy, done;
    int              errors = 0, checks = 0;

    instr_sequencer_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

    instr_sequencer #(.ADDR(ADDR), .WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .pc(pc), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: registered read, data held until the next read.
    logic [7:0] mem [LENGTH];
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cs && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [1:0] sel; logic [1:0] op; logic [7:0] wd; } ev_t;
    wr_t wq[$];
    ev_t evq[$];
    int  cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.mem_cs && bus.mem_we) wq.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
        if (bus.rf_we) evq.push_back('{cyc, bus.rf_sel, bus.alu_op, bus.rf_wdata});
    end

    // Reference model: walk the program word by word and list the writebacks.
    logic [7:0] prog [LENGTH];
    ev_t        exp_ev[$];
    int         exp_pc;
    int         run_ebase;

    function automatic void model(input int halt_at);
        exp_ev.delete();
        for (int i = 0; i < LENGTH; i++) begin
            if (prog[i] == 8'hFF) begin exp_pc = i; return; end
            exp_ev.push_back('{0, prog[i][7:6], prog[i][5:4], {4'h0, prog[i][3:0]}});
            if (i == LENGTH - 1) begin exp_pc = i; return; end
            if (i == halt_at) begin exp_pc = i + 1; return; end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input int gap_after, input int gap_len, input bit hold_start);
        int base = wq.size();
        start = hold_start;
        for (int i = 0; i < LENGTH; i++) begin
            if (i == gap_after) begin
                bus.load_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    chk("gap_no_write", wq.size() - base, i);
                    chk("gap_ready", bus.load_ready, 1);
                end
            end
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            tick();
            chk("load_not_busy", busy, 0);
        end
        bus.load_valid = 1'b0;
        start = 1'b0;
        chk("load_count", wq.size() - base, LENGTH);
        for (int i = 0; i < LENGTH && base + i < wq.size(); i++) begin
            chk("load_addr", wq[base+i].addr, i);
            chk("load_data", wq[base+i].data, prog[i]);
        end
        tick();
        chk("load_end_ready", bus.load_ready, 1);
        chk("load_end_busy", busy, 0);
        chk("load_end_count", wq.size() - base, LENGTH);
    endtask

    task automatic run_prog(input int halt_at);
        int wbase = wq.size();
        bit sent = 1'b0;
        run_ebase = evq.size();
        model(halt_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_pc0", pc, 0);
        for (int c = 0; c < 300 && !done; c++) begin
            if (halt_at >= 0 && !sent && pc == halt_at && bus.mem_cs && !bus.mem_we) begin
                halt_req = 1'b1;
                sent = 1'b1;
            end
            tick();
            halt_req = 1'b0;
        end
        chk("run_done", done, 1);
        chk("run_pc", pc, exp_pc);
        chk("run_halt_busy", busy, 0);
        chk("run_halt_ready", bus.load_ready, 0);
        chk("run_no_mem_write", wq.size() - wbase, 0);
        chk("run_wb_count", evq.size() - run_ebase, exp_ev.size());
        for (int k = 0; k < exp_ev.size() && run_ebase + k < evq.size(); k++) begin
            chk("wb_sel", evq[run_ebase+k].sel, exp_ev[k].sel);
            chk("wb_op", evq[run_ebase+k].op, exp_ev[k].op);
            chk("wb_data", evq[run_ebase+k].wd, exp_ev[k].wd);
            if (k > 0) chk("wb_spacing", evq[run_ebase+k].cyc - evq[run_ebase+k-1].cyc, 3);
        end
        if (exp_ev.size() > 0) begin
            chk("hold_sel", bus.rf_sel, exp_ev[exp_ev.size()-1].sel);
            chk("hold_op", bus.alu_op, exp_ev[exp_ev.size()-1].op);
            chk("hold_data", bus.rf_wdata, exp_ev[exp_ev.size()-1].wd);
        end
    endtask

    task automatic to_idle();
        int wbase = wq.size();
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h11;
        tick();
        bus.load_valid = 1'b0;
        chk("halt_ignores_load", wq.size() - wbase, 0);
        chk("halt_stays_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_ready", bus.load_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic random_prog();
        for (int i = 0; i < LENGTH; i++) prog[i] = 8'($urandom_range(0, 254));
    endtask

    initial begin
        int  ff_pos, h;
        bit  found;
        reset = 1'b1; start = 1'b0; halt_req = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.load_ready, 1);
        chk("rst_cs", bus.mem_cs, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_rf_sel", bus.rf_sel, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);

        // Directed program: 05, 46, 9A, random body, halt opcode at the last word.
        random_prog();
        prog[0] = 8'h05; prog[1] = 8'h46; prog[2] = 8'h9A; prog[LENGTH-1] = 8'hFF;
        load_prog(-1, 0, 1'b0);
        run_prog(-1);
        chk("first_wb_sel", evq[run_ebase].sel, 0);
        chk("first_wb_data", evq[run_ebase].wd, 8'h05);
        chk("second_wb_sel", evq[run_ebase+1].sel, 1);
        chk("second_wb_data", evq[run_ebase+1].wd, 8'h06);
        chk("second_wb_op", evq[run_ebase+1].op, 0);
        chk("ff_halt_pc", pc, 15);
        to_idle();
        run_prog(2);
        chk("halt_req_pc", pc, 3);
        chk("halt_req_sel", evq[evq.size()-1].sel, 2);
        chk("halt_req_data", evq[evq.size()-1].wd, 8'h0A);
        to_idle();

        // Random program loaded with start held high, halt opcode somewhere inside.
        random_prog();
        ff_pos = $urandom_range(6, LENGTH - 1);
        prog[ff_pos] = 8'hFF;
        load_prog(-1, 0, 1'b1);
        run_prog(-1);
        to_idle();
        h = $urandom_range(0, ff_pos - 1);
        run_prog(h);
        to_idle();

        // Random program with a load gap, run to end, then reset mid-run.
        random_prog();
        load_prog(4, 3, 1'b0);
        run_prog(-1);
        chk("end_pc_no_wrap", pc, LENGTH - 1);
        to_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (pc == 7 && bus.mem_cs && !bus.mem_we) found = 1'b1;
            else tick();
        end
        chk("reach_fetch_pc7", found, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_rf_we", bus.rf_we, 0);
        chk("mid_rst_cs", bus.mem_cs, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bus.load_ready, 1);
        run_prog(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
